// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder: header field positions,
// FSM state encoding and the length-byte decode helper.
package uart_cmd_decoder_pkg;

    localparam int ADDR_W             = 6;
    localparam int HDR_RD_BIT         = 7;
    localparam int HDR_RSV_BIT        = 6;
    localparam int DEFAULT_RD_TIMEOUT = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_WDATA   = 3'd2,
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4,
        ST_TX_WAIT = 3'd5,
        ST_TX_HOLD = 3'd6
    } cmd_state_t;

    // A length byte of zero encodes a full 256-byte burst.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/uart_cmd_decoder.sv
// Turns a {hdr, len, data...} byte stream from the UART receiver into register-bus
// write/read bursts and streams read data back to the UART transmitter.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter int RD_TIMEOUT = DEFAULT_RD_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_ready,
    input  logic              rx_error,
    input  logic              rx_endofpacket,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_bytecnt,
    output logic [7:0]        reg_wdata,
    output logic              reg_write,
    output logic              reg_read,
    input  logic [7:0]        reg_rdata,
    input  logic              reg_rdata_valid,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              cmd_busy,
    output logic              cmd_done,
    output logic              cmd_error,
    output cmd_state_t        dbg_state
);

    localparam logic [15:0] TMO_LAST = 16'(RD_TIMEOUT - 1);

    cmd_state_t        r_state;
    cmd_state_t        w_state_nxt;

    logic [ADDR_W-1:0] r_reg_addr;
    logic [7:0]        r_reg_bytecnt;
    logic [7:0]        r_reg_wdata;
    logic              r_reg_write;
    logic              r_reg_read;
    logic [7:0]        r_tx_data;
    logic              r_tx_start;
    logic              r_cmd_done;
    logic              r_cmd_error;
    logic              r_is_read;
    logic [8:0]        r_total;
    logic [8:0]        r_remaining;
    logic [15:0]       r_tmo;

    logic              w_rx_byte;
    logic              w_abort;
    logic              w_last;
    logic              w_more;
    logic              w_tmo_expired;
    logic [7:0]        w_index;

    logic              w_wr_nxt;
    logic              w_rd_nxt;
    logic              w_txs_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;

    // A framing error on the same cycle as rx_ready kills the byte.
    assign w_rx_byte     = rx_ready & ~rx_error;
    assign w_abort       = rx_error | rx_endofpacket;
    assign w_last        = (r_remaining == 9'd1);
    assign w_more        = (r_remaining > 9'd1);
    assign w_tmo_expired = (r_tmo == TMO_LAST);
    assign w_index       = 8'(r_total - r_remaining);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rx_byte && !rx_data[HDR_RSV_BIT]) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (rx_ready) begin
                    w_state_nxt = r_is_read ? ST_RD_REQ : ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (rx_ready && w_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (reg_rdata_valid) begin
                    w_state_nxt = ST_TX_WAIT;
                end else if (w_tmo_expired) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    w_state_nxt = ST_TX_HOLD;
                end
            end
            ST_TX_HOLD: begin
                w_state_nxt = w_more ? ST_RD_REQ : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: next value of every registered strobe
    // ------------------------------------------------------------------
    // tx handshake: tx_start is a single-cycle request issued only when
    // tx_busy was low on the launching edge; tx_data stays put until the
    // next read response, so it is stable for the whole busy window.
    always_comb begin
        w_wr_nxt   = 1'b0;
        w_rd_nxt   = 1'b0;
        w_txs_nxt  = 1'b0;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_err_nxt = w_rx_byte && rx_data[HDR_RSV_BIT];
            end
            ST_LEN: begin
                w_err_nxt = w_abort;
                w_rd_nxt  = !w_abort && rx_ready && r_is_read;
            end
            ST_WDATA: begin
                w_err_nxt  = w_abort;
                w_wr_nxt   = !w_abort && rx_ready;
                w_done_nxt = !w_abort && rx_ready && w_last;
            end
            ST_RD_WAIT: begin
                w_err_nxt = !reg_rdata_valid && w_tmo_expired;
            end
            ST_TX_WAIT: begin
                w_txs_nxt = !tx_busy;
            end
            ST_TX_HOLD: begin
                w_rd_nxt   = w_more;
                w_done_nxt = !w_more;
            end
            default: begin
                w_err_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_reg_addr    <= '0;
            r_reg_bytecnt <= '0;
            r_reg_wdata   <= '0;
            r_reg_write   <= 1'b0;
            r_reg_read    <= 1'b0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
            r_cmd_done    <= 1'b0;
            r_cmd_error   <= 1'b0;
            r_is_read     <= 1'b0;
            r_total       <= '0;
            r_remaining   <= '0;
            r_tmo         <= '0;
        end else begin
            r_reg_write <= w_wr_nxt;
            r_reg_read  <= w_rd_nxt;
            r_tx_start  <= w_txs_nxt;
            r_cmd_done  <= w_done_nxt;
            r_cmd_error <= w_err_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_rx_byte && !rx_data[HDR_RSV_BIT]) begin
                        r_reg_addr <= rx_data[ADDR_W-1:0];
                        r_is_read  <= rx_data[HDR_RD_BIT];
                    end
                end
                ST_LEN: begin
                    if (!w_abort && rx_ready) begin
                        r_total       <= len_to_count(rx_data);
                        r_remaining   <= len_to_count(rx_data);
                        r_reg_bytecnt <= '0;
                    end
                end
                ST_WDATA: begin
                    if (w_wr_nxt) begin
                        r_reg_wdata   <= rx_data;
                        r_reg_bytecnt <= w_index;
                        r_remaining   <= r_remaining - 9'd1;
                    end
                end
                ST_RD_REQ: begin
                    r_tmo <= '0;
                end
                ST_RD_WAIT: begin
                    if (reg_rdata_valid) begin
                        r_tx_data <= reg_rdata;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
                ST_TX_HOLD: begin
                    r_remaining   <= r_remaining - 9'd1;
                    r_reg_bytecnt <= r_reg_bytecnt + 8'd1;
                end
                default: begin
                    r_tmo <= r_tmo;
                end
            endcase
        end
    end

    assign reg_addr    = r_reg_addr;
    assign reg_bytecnt = r_reg_bytecnt;
    assign reg_wdata   = r_reg_wdata;
    assign reg_write   = r_reg_write;
    assign reg_read    = r_reg_read;
    assign tx_data     = r_tx_data;
    assign tx_start    = r_tx_start;
    assign cmd_done    = r_cmd_done;
    assign cmd_error   = r_cmd_error;
    assign cmd_busy    = (r_state != ST_IDLE);
    assign dbg_state   = r_state;

    a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0({r_reg_write, r_reg_read, r_tx_start}));
    a_done_xor_err: assert property (@(posedge clk) disable iff (!reset_n)
        !(r_cmd_done && r_cmd_error));

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: per-scenario tasks push expected bus
// events, a negedge monitor pops and compares them as the DUT emits strobes.
module tb_uart_cmd_decoder;
    import uart_cmd_decoder_pkg::*;

    localparam int TB_RD_TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic        rx_error = 1'b0;
    logic        rx_endofpacket = 1'b0;
    logic [5:0]  reg_addr;
    logic [7:0]  reg_bytecnt;
    logic [7:0]  reg_wdata;
    logic        reg_write;
    logic        reg_read;
    logic [7:0]  reg_rdata = '0;
    logic        reg_rdata_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        cmd_busy;
    logic        cmd_done;
    logic        cmd_error;
    cmd_state_t  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [21:0] exp_wr_q[$];   // {addr, bytecnt, wdata}
    logic [13:0] exp_rd_q[$];   // {addr, bytecnt}
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  rd_src_q[$];   // data the register-file model returns

    int          cyc = 0;
    int          n_done = 0;
    int          n_err = 0;
    bit          done_with_wr = 1'b0;
    int          last_rd_cyc = 0;
    int          last_err_cyc = 0;
    int          last_valid_cyc = -100;
    bit          rd_resp_en = 1'b1;
    bit          tx_force = 1'b0;
    int          tx_cnt = 0;
    logic [7:0]  last_tx_data = '0;
    logic [21:0] e_wr;
    logic [13:0] e_rd;
    logic [7:0]  e_tx;

    uart_cmd_decoder #(.RD_TIMEOUT(TB_RD_TIMEOUT)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .rx_data         (rx_data),
        .rx_ready        (rx_ready),
        .rx_error        (rx_error),
        .rx_endofpacket  (rx_endofpacket),
        .reg_addr        (reg_addr),
        .reg_bytecnt     (reg_bytecnt),
        .reg_wdata       (reg_wdata),
        .reg_write       (reg_write),
        .reg_read        (reg_read),
        .reg_rdata       (reg_rdata),
        .reg_rdata_valid (reg_rdata_valid),
        .tx_data         (tx_data),
        .tx_start        (tx_start),
        .tx_busy         (tx_busy),
        .cmd_busy        (cmd_busy),
        .cmd_done        (cmd_done),
        .cmd_error       (cmd_error),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard + transmitter model ----------------
    always @(negedge clk) begin
        if (!reset_n) begin
            tx_cnt = 0;
        end else begin
            if (reg_write || reg_read || tx_start) begin
                vectors++;
                if ($countones({reg_write, reg_read, tx_start}) > 1) begin
                    miscompares++;
                    $display("FAIL strobe_overlap: got wr=%0b rd=%0b txs=%0b, expected at most one",
                             reg_write, reg_read, tx_start);
                end
            end
            if (reg_write) begin
                vectors++;
                if (exp_wr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_write: got addr=%0d cnt=%0d data=%h, expected none",
                             reg_addr, reg_bytecnt, reg_wdata);
                end else begin
                    e_wr = exp_wr_q.pop_front();
                    if ({reg_addr, reg_bytecnt, reg_wdata} !== e_wr) begin
                        miscompares++;
                        $display("FAIL write: got addr=%0d cnt=%0d data=%h, expected addr=%0d cnt=%0d data=%h",
                                 reg_addr, reg_bytecnt, reg_wdata, e_wr[21:16], e_wr[15:8], e_wr[7:0]);
                    end
                end
            end
            if (reg_read) begin
                vectors++;
                last_rd_cyc = cyc;
                if (exp_rd_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_read: got addr=%0d cnt=%0d, expected none",
                             reg_addr, reg_bytecnt);
                end else begin
                    e_rd = exp_rd_q.pop_front();
                    if ({reg_addr, reg_bytecnt} !== e_rd) begin
                        miscompares++;
                        $display("FAIL read_req: got addr=%0d cnt=%0d, expected addr=%0d cnt=%0d",
                                 reg_addr, reg_bytecnt, e_rd[13:8], e_rd[7:0]);
                    end
                end
            end
            if (tx_start) begin
                vectors++;
                if (exp_tx_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_tx: got tx_data=%h, expected none", tx_data);
                end else begin
                    e_tx = exp_tx_q.pop_front();
                    if (tx_data !== e_tx) begin
                        miscompares++;
                        $display("FAIL tx_data: got %h, expected %h", tx_data, e_tx);
                    end
                end
                vectors++;
                if (tx_busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL tx_while_busy: got tx_busy=%0b at tx_start, expected 0", tx_busy);
                end
                vectors++;
                if (cyc - last_valid_cyc < 2) begin
                    miscompares++;
                    $display("FAIL tx_latency: got %0d clk after rdata_valid, expected >= 2",
                             cyc - last_valid_cyc);
                end
            end
            if (tx_cnt != 0) begin
                vectors++;
                if (tx_data !== last_tx_data) begin
                    miscompares++;
                    $display("FAIL tx_hold: got tx_data=%h while busy, expected %h", tx_data, last_tx_data);
                end
            end
            if (cmd_done === 1'b1) begin
                n_done++;
                done_with_wr = reg_write;
            end
            if (cmd_error === 1'b1) begin
                n_err++;
                last_err_cyc = cyc;
            end
            if (cmd_done === 1'b1 && cmd_error === 1'b1) begin
                vectors++;
                miscompares++;
                $display("FAIL done_and_error: got both high, expected exclusive");
            end
            if (tx_start) begin
                tx_cnt = 4;
                last_tx_data = tx_data;
            end else if (tx_cnt != 0) begin
                tx_cnt--;
            end
        end
        tx_busy = tx_force || (tx_cnt != 0);
    end

    // ---------------- register-file model: answers reg_read after 3 clk ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (reg_read === 1'b1 && rd_resp_en) begin
                repeat (3) @(negedge clk);
                reg_rdata = (rd_src_q.size() != 0) ? rd_src_q.pop_front() : 8'hEE;
                reg_rdata_valid = 1'b1;
                last_valid_cyc = cyc;
                @(negedge clk);
                reg_rdata_valid = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_eop();
        @(negedge clk);
        rx_endofpacket = 1'b1;
        @(negedge clk);
        rx_endofpacket = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (cmd_busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (cmd_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle_timeout: got cmd_busy=%0b after %0d clk, expected 0", name, cmd_busy, budget);
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({reg_write, reg_read, tx_start, cmd_done, cmd_error, cmd_busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: got %b, expected 000000",
                     {reg_write, reg_read, tx_start, cmd_done, cmd_error, cmd_busy});
        end
        vectors++;
        if ({reg_addr, reg_bytecnt, reg_wdata, tx_data} !== 30'b0) begin
            miscompares++;
            $display("FAIL reset_data: got addr=%0d cnt=%0d wdata=%h tx=%h, expected all 0",
                     reg_addr, reg_bytecnt, reg_wdata, tx_data);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if (dbg_state !== ST_IDLE || cmd_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got state=%0d busy=%0b, expected state=0 busy=0", dbg_state, cmd_busy);
        end
    endtask

    task automatic test_write();
        int d0 = n_done;
        int e0 = n_err;
        exp_wr_q.push_back({6'd5, 8'd0, 8'hAA});
        exp_wr_q.push_back({6'd5, 8'd1, 8'h55});
        send_byte(8'h05, 1);
        send_byte(8'h02, 1);
        send_byte(8'hAA, 2);
        send_byte(8'h55, 1);
        wait_idle(50, "write");
        vectors++;
        if (exp_wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL write_missing: got %0d writes pending, expected 0", exp_wr_q.size());
        end
        vectors++;
        if (n_done - d0 != 1 || n_err != e0) begin
            miscompares++;
            $display("FAIL write_status: got done=%0d err=%0d, expected done=1 err=0", n_done - d0, n_err - e0);
        end
        vectors++;
        if (done_with_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL write_done_align: got reg_write=%0b with cmd_done, expected 1", done_with_wr);
        end
    endtask

    task automatic test_read();
        int d0 = n_done;
        int e0 = n_err;
        logic [7:0] vals[3] = '{8'h11, 8'h22, 8'h33};
        tx_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rd_src_q.push_back(vals[i]);
            exp_rd_q.push_back({6'd3, 8'(i)});
            exp_tx_q.push_back(vals[i]);
        end
        fork
            begin
                repeat (20) @(negedge clk);
                tx_force = 1'b0;
            end
        join_none
        send_byte(8'h83, 1);
        send_byte(8'h03, 0);
        wait_idle(400, "read");
        vectors++;
        if (exp_rd_q.size() != 0 || exp_tx_q.size() != 0) begin
            miscompares++;
            $display("FAIL read_missing: got rd=%0d tx=%0d pending, expected 0 0", exp_rd_q.size(), exp_tx_q.size());
        end
        vectors++;
        if (n_done - d0 != 1 || n_err != e0) begin
            miscompares++;
            $display("FAIL read_status: got done=%0d err=%0d, expected done=1 err=0", n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_len256();
        int d0 = n_done;
        int e0 = n_err;
        logic [7:0] b;
        send_byte(8'h01, 1);
        send_byte(8'h00, 1);
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_wr_q.push_back({6'd1, 8'(i), b});
            send_byte(b, 1);
        end
        wait_idle(50, "len256");
        vectors++;
        if (exp_wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL len256_missing: got %0d writes pending, expected 0", exp_wr_q.size());
        end
        vectors++;
        if (n_done - d0 != 1 || n_err != e0) begin
            miscompares++;
            $display("FAIL len256_status: got done=%0d err=%0d, expected done=1 err=0", n_done - d0, n_err - e0);
        end
    endtask

    task automatic test_eop_abort();
        int d0 = n_done;
        int e0 = n_err;
        exp_wr_q.push_back({6'd2, 8'd0, 8'h10});
        send_byte(8'h02, 1);
        send_byte(8'h04, 1);
        send_byte(8'h10, 1);
        pulse_eop();
        wait_idle(20, "eop");
        vectors++;
        if (n_err - e0 != 1 || n_done != d0 || exp_wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL eop_abort: got err=%0d done=%0d pending=%0d, expected err=1 done=0 pending=0",
                     n_err - e0, n_done - d0, exp_wr_q.size());
        end
        // back-to-back recovery
        exp_wr_q.push_back({6'd7, 8'd0, 8'h3C});
        send_byte(8'h07, 0);
        send_byte(8'h01, 0);
        send_byte(8'h3C, 0);
        wait_idle(20, "eop_recover");
        vectors++;
        if (n_done - d0 != 1 || exp_wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL eop_recover: got done=%0d pending=%0d, expected done=1 pending=0",
                     n_done - d0, exp_wr_q.size());
        end
    endtask

    task automatic test_bad_hdr();
        int e0 = n_err;
        send_byte(8'h40, 2);
        vectors++;
        if (n_err - e0 != 1 || cmd_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_hdr: got err=%0d busy=%0b, expected err=1 busy=0", n_err - e0, cmd_busy);
        end
    endtask

    task automatic test_rd_timeout();
        int d0 = n_done;
        int e0 = n_err;
        int lat;
        rd_resp_en = 1'b0;
        exp_rd_q.push_back({6'd5, 8'd0});
        send_byte(8'h85, 1);
        send_byte(8'h01, 0);
        wait_idle(100, "timeout");
        lat = last_err_cyc - last_rd_cyc;
        vectors++;
        if (n_err - e0 != 1 || n_done != d0 || exp_rd_q.size() != 0) begin
            miscompares++;
            $display("FAIL timeout_status: got err=%0d done=%0d rd_pending=%0d, expected 1 0 0",
                     n_err - e0, n_done - d0, exp_rd_q.size());
        end
        vectors++;
        if (lat < TB_RD_TIMEOUT || lat > TB_RD_TIMEOUT + 2) begin
            miscompares++;
            $display("FAIL timeout_latency: got %0d clk, expected %0d..%0d", lat, TB_RD_TIMEOUT, TB_RD_TIMEOUT + 2);
        end
        rd_resp_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int d0;
        int n = 0;
        bit hit = 1'b0;
        logic [7:0] vals[4] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        for (int i = 0; i < 4; i++) begin
            rd_src_q.push_back(vals[i]);
            exp_rd_q.push_back({6'd4, 8'(i)});
            exp_tx_q.push_back(vals[i]);
        end
        send_byte(8'h84, 1);
        send_byte(8'h04, 0);
        while (!hit && n < 200) begin
            @(negedge clk);
            n++;
            hit = (reg_read === 1'b1 && reg_bytecnt == 8'd1);
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL rstmid_no_second_read: got none in 200 clk, expected reg_read cnt=1");
        end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({reg_write, reg_read, tx_start, cmd_done, cmd_error, cmd_busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL rstmid_strobes: got %b, expected 000000",
                     {reg_write, reg_read, tx_start, cmd_done, cmd_error, cmd_busy});
        end
        vectors++;
        if ({reg_addr, reg_bytecnt, reg_wdata, tx_data} !== 30'b0) begin
            miscompares++;
            $display("FAIL rstmid_data: got addr=%0d cnt=%0d wdata=%h tx=%h, expected all 0",
                     reg_addr, reg_bytecnt, reg_wdata, tx_data);
        end
        repeat (6) @(negedge clk);
        rd_src_q.delete();
        exp_rd_q.delete();
        exp_tx_q.delete();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        d0 = n_done;
        exp_wr_q.push_back({6'd9, 8'd0, 8'h77});
        send_byte(8'h09, 1);
        send_byte(8'h01, 1);
        send_byte(8'h77, 1);
        wait_idle(20, "rstmid_fresh");
        vectors++;
        if (n_done - d0 != 1 || exp_wr_q.size() != 0) begin
            miscompares++;
            $display("FAIL rstmid_fresh: got done=%0d pending=%0d, expected done=1 pending=0",
                     n_done - d0, exp_wr_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_len256();
        test_eop_abort();
        test_bad_hdr();
        test_rd_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
